cdb_broadcaster: RTL and testbench
==================================

# cdb_broadcaster

Transmit end of the common data bus. Collects completed-result tags from the functional units and buffers them in an age-ordered queue. Each cycle it broadcasts up to `N` tags on `CDB_tags`/`CDB_valid`, which the reservation station, map table and ROB consume for wakeup. Buffered tags follow branch-mask resolution and squash, so a squashed result is never broadcast.

## Interface
Parameters:
- `N`, default `` `N `` (2): CDB broadcast width.
- `NUM_FU`, default 4: completing functional-unit ports.
- `BUF_DEPTH`, default 8: queue entries; must be ≥ `NUM_FU` + `N`.
- `PREG_BITS`, default 6: physical register tag width (`PHYS_REG_IDX`).
- `B_MASK_WIDTH`, default 4: branch mask width.

Ports:
- `clock` in 1: sole clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `fu_valid` in `NUM_FU`: result completing on port k.
- `fu_tag` in `NUM_FU`×`PREG_BITS`: destination tag per port.
- `fu_b_mask` in `NUM_FU`×`B_MASK_WIDTH`: branch mask per port.
- `fu_stall` out `NUM_FU`: all bits equal; when 1, inputs are ignored and the FU must hold.
- `b_mm_resolve` in `B_MASK_WIDTH`: one-hot branch being resolved.
- `b_mm_mispred` in 1: resolved branch mispredicted.
- `CDB_tags` out `N`×`PREG_BITS`: registered broadcast tags.
- `CDB_valid` out `N`: registered per-lane valid.
- `buf_count` out clog2(`BUF_DEPTH`+1): occupied entries.

## Operation
- Reset values: `CDB_valid`=0, `CDB_tags`=0, `buf_count`=0, `fu_stall`=0, all entries invalid.
- Queue model: collapsing queue, index 0 is oldest. Age order is buffered entries first, then this cycle's accepted inputs in ascending FU index.
- Accept: when `fu_stall`=0, each port with `fu_valid` is appended. Stall is combinational from the registered count: `fu_stall` = (`buf_count` > `BUF_DEPTH` − `NUM_FU`). This guarantees no overflow.
- Resolve, no mispredict: clear the `b_mm_resolve` bit in every stored mask and in each incoming mask before storing.
- Resolve with mispredict: drop every stored or incoming entry whose mask intersects `b_mm_resolve`. Survivors collapse and keep relative order.
- Select: after the squash, the oldest `min(N, survivors)` eligible entries go to lanes 0.. in age order. They are registered onto `CDB_*` and removed. Unused lanes have valid=0 and tag=0.
- A broadcast already on `CDB_*` is never recalled. The consumer filters it by its own squash.
- `buf_count`_next = count + accepted − squashed − selected.

## Timing
- Registered-output latency: a tag accepted in cycle t appears no earlier than cycle t+1 (with bypass) or t+2 (without).
- Squash and resolve take effect on entries in the same cycle they are presented.
- Reset asserted mid-operation: the queue and outputs clear asynchronously, and pending tags are lost.
- Full boundary: while stalled, only draining and squash change `buf_count`.
- Empty boundary: with no inputs, `CDB_valid`=0 the next cycle.

## Configuration
- `CDB_BYPASS_EN` defined: incoming accepted results are eligible for selection in the cycle they arrive, subject to age order. Single-result latency is 1 cycle.
- `CDB_BYPASS_EN` undefined: incoming results are only written to the queue and become eligible the following cycle. Latency is 2 cycles; the selector sees only stored entries.

## Structure
- Shared package: `CDB_ENTRY` typedef {`PHYS_REG_IDX` tag; `B_MASK` b_mask}, `PHYS_REG_IDX` and `B_MASK_MASK` types, and constants for `N` and `B_MASK_WIDTH`.
- One sub-module, `cdb_pick_n`: combinational first-N-valid selector over an age-ordered valid vector. It returns `N` one-hot grants plus a grant mask used for collapsing.

## Test plan
- Reset and idle: hold `reset`=0 then release with `fu_valid`=0 → `CDB_valid`=00, `buf_count`=0, `fu_stall`=0 on every cycle.
- Single result: `fu_valid`=0001, tag 7 at t → `CDB_valid`=01 and `CDB_tags[0]`=7 at t+1 (bypass) or t+2 (no bypass); `buf_count` returns to 0.
- Burst ordering: ports 0–3 carry tags 10,11,12,13 at t (bypass) → t+1 lanes {10,11}, t+2 lanes {12,13}, t+3 `CDB_valid`=00.
- Mispredict squash: stored tag 20 (mask 0010) and tag 21 (mask 0001); apply `b_mm_mispred`=1 with resolve 0010 → tag 20 never appears, tag 21 broadcasts next cycle, `buf_count` drops by 2 across those cycles.
- Correct resolve: stored mask 0011, resolve 0001 without mispredict → entry keeps mask 0010 and is still broadcast. A later mispredict on 0001 does not drop it.
- Backpressure: drive 4 results per cycle until `buf_count`=5 → `fu_stall`=1111 and held inputs are ignored. `buf_count` never exceeds 8, and stall deasserts once `buf_count` ≤ 4.

Source files
------------

// File: rtl/cdb_broadcaster_pkg.sv
// Shared entry types and default sizes for the common-data-bus broadcaster.
package cdb_broadcaster_pkg;

    localparam int unsigned CDB_N_DEF        = 2;
    localparam int unsigned CDB_PREG_BITS    = 6;
    localparam int unsigned CDB_B_MASK_WIDTH = 4;

    typedef logic [CDB_PREG_BITS-1:0]    PHYS_REG_IDX;
    typedef logic [CDB_B_MASK_WIDTH-1:0] B_MASK;
    typedef B_MASK                       B_MASK_MASK;

    typedef struct packed {
        PHYS_REG_IDX tag;
        B_MASK       b_mask;
    } CDB_ENTRY;

endpackage

// File: rtl/cdb_pick_n.sv
// Combinational first-N-valid selector over an age-ordered valid vector (bit 0 oldest).
module cdb_pick_n
    import cdb_broadcaster_pkg::*;
#(
    parameter int unsigned N = CDB_N_DEF,
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]   valid_i,
    output logic [N*W-1:0] grant_o,
    output logic [W-1:0]   grant_mask_o
);

    logic [W-1:0] avail;
    logic         found;

    always_comb begin
        avail        = valid_i;
        grant_o      = '0;
        grant_mask_o = '0;
        found        = 1'b0;
        for (int l = 0; l < N; l++) begin
            found = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (avail[i] && !found) begin
                    grant_o[l*W+i] = 1'b1;
                    found          = 1'b1;
                end
            end
            avail = avail & ~grant_o[l*W +: W];
        end
        grant_mask_o = valid_i & ~avail;
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: age-ordered collapsing tag queue with branch-mask squash, N-wide broadcast.
// Define CDB_BYPASS_EN to let this cycle's accepted results be selected in the same cycle.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int unsigned N            = CDB_N_DEF,
    parameter int unsigned NUM_FU       = 4,
    parameter int unsigned BUF_DEPTH    = 8,
    parameter int unsigned PREG_BITS    = CDB_PREG_BITS,
    parameter int unsigned B_MASK_WIDTH = CDB_B_MASK_WIDTH,
    localparam int unsigned CW          = $clog2(BUF_DEPTH + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_FU-1:0]              fu_valid,
    input  logic [NUM_FU*PREG_BITS-1:0]    fu_tag,
    input  logic [NUM_FU*B_MASK_WIDTH-1:0] fu_b_mask,
    output logic [NUM_FU-1:0]              fu_stall,
    input  logic [B_MASK_WIDTH-1:0]        b_mm_resolve,
    input  logic                           b_mm_mispred,
    output logic [N*PREG_BITS-1:0]         CDB_tags,
    output logic [N-1:0]                   CDB_valid,
    output logic [CW-1:0]                  buf_count
);

    localparam int unsigned TOT = BUF_DEPTH + NUM_FU;
`ifdef CDB_BYPASS_EN
    localparam int unsigned SEL_W = TOT;
`else
    localparam int unsigned SEL_W = BUF_DEPTH;
`endif
    localparam logic [CW-1:0] STALL_THR = CW'(BUF_DEPTH - NUM_FU);

    logic [PREG_BITS-1:0]    q_tag_q  [BUF_DEPTH];
    logic [PREG_BITS-1:0]    q_tag_d  [BUF_DEPTH];
    logic [B_MASK_WIDTH-1:0] q_mask_q [BUF_DEPTH];
    logic [B_MASK_WIDTH-1:0] q_mask_d [BUF_DEPTH];
    logic [CW-1:0]           count_q, count_d;
    logic [N*PREG_BITS-1:0]  cdb_tags_q, cdb_tags_d;
    logic [N-1:0]            cdb_valid_q, cdb_valid_d;

    logic                    stall;
    logic [PREG_BITS-1:0]    c_tag  [TOT];
    logic [B_MASK_WIDTH-1:0] c_mask [TOT];
    logic [TOT-1:0]          c_valid;
    logic [TOT-1:0]          taken;
    logic [N*SEL_W-1:0]      grant;
    logic [SEL_W-1:0]        grant_mask;
    int unsigned             wr_idx;

    // Stall depends only on the registered count, so an accepting cycle can never overflow.
    assign stall     = count_q > STALL_THR;
    assign fu_stall  = {NUM_FU{stall}};
    assign CDB_tags  = cdb_tags_q;
    assign CDB_valid = cdb_valid_q;
    assign buf_count = count_q;

    // Candidates in age order: stored entries, then accepted inputs by FU index.
    always_comb begin
        c_valid = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            c_tag[i]   = q_tag_q[i];
            c_mask[i]  = q_mask_q[i];
            c_valid[i] = CW'(i) < count_q;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            c_tag[BUF_DEPTH+k]   = fu_tag[k*PREG_BITS +: PREG_BITS];
            c_mask[BUF_DEPTH+k]  = fu_b_mask[k*B_MASK_WIDTH +: B_MASK_WIDTH];
            c_valid[BUF_DEPTH+k] = fu_valid[k] && !stall;
        end
        for (int i = 0; i < TOT; i++) begin
            if (b_mm_mispred && |(c_mask[i] & b_mm_resolve)) begin
                c_valid[i] = 1'b0;
            end
            c_mask[i] = c_mask[i] & ~b_mm_resolve;
        end
    end

    cdb_pick_n #(
        .N (N),
        .W (SEL_W)
    ) u_pick (
        .valid_i      (c_valid[SEL_W-1:0]),
        .grant_o      (grant),
        .grant_mask_o (grant_mask)
    );

    always_comb begin
        cdb_valid_d = '0;
        cdb_tags_d  = '0;
        for (int l = 0; l < N; l++) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (grant[l*SEL_W+i]) begin
                    cdb_valid_d[l] = 1'b1;
                    cdb_tags_d[l*PREG_BITS +: PREG_BITS] =
                        cdb_tags_d[l*PREG_BITS +: PREG_BITS] | c_tag[i];
                end
            end
        end

        // Collapse survivors that were not broadcast, preserving relative age.
        taken              = '0;
        taken[SEL_W-1:0]   = grant_mask;
        wr_idx             = 0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            q_tag_d[i]  = '0;
            q_mask_d[i] = '0;
        end
        for (int i = 0; i < TOT; i++) begin
            if (c_valid[i] && !taken[i] && wr_idx < BUF_DEPTH) begin
                q_tag_d[wr_idx]  = c_tag[i];
                q_mask_d[wr_idx] = c_mask[i];
                wr_idx           = wr_idx + 1;
            end
        end
        count_d = CW'(wr_idx);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            cdb_valid_q <= '0;
            cdb_tags_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                q_tag_q[i]  <= '0;
                q_mask_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tags_q  <= cdb_tags_d;
            q_tag_q     <= q_tag_d;
            q_mask_q    <= q_mask_d;
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: queue-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    localparam int N         = 2;
    localparam int NUM_FU    = 4;
    localparam int BUF_DEPTH = 8;
    localparam int PB        = 6;
    localparam int BW        = 4;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    typedef CDB_ENTRY ent_q_t[$];

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [NUM_FU-1:0]      fu_valid = '0;
    logic [NUM_FU*PB-1:0]   fu_tag = '0;
    logic [NUM_FU*BW-1:0]   fu_b_mask = '0;
    logic [NUM_FU-1:0]      fu_stall;
    logic [BW-1:0]          b_mm_resolve = '0;
    logic                   b_mm_mispred = 1'b0;
    logic [N*PB-1:0]        CDB_tags;
    logic [N-1:0]           CDB_valid;
    logic [3:0]             buf_count;

    always #5 clock = ~clock;

    cdb_broadcaster dut (
        .clock        (clock),
        .reset        (reset),
        .fu_valid     (fu_valid),
        .fu_tag       (fu_tag),
        .fu_b_mask    (fu_b_mask),
        .fu_stall     (fu_stall),
        .b_mm_resolve (b_mm_resolve),
        .b_mm_mispred (b_mm_mispred),
        .CDB_tags     (CDB_tags),
        .CDB_valid    (CDB_valid),
        .buf_count    (buf_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of pending results.
    ent_q_t          mq;
    logic [N-1:0]    m_valid = '0;
    logic [N*PB-1:0] m_tags  = '0;

    function automatic ent_q_t squash(input ent_q_t in_q, input logic [BW-1:0] res,
                                      input logic mis);
        ent_q_t   o;
        CDB_ENTRY e;
        foreach (in_q[i]) begin
            e = in_q[i];
            if (!(mis && ((e.b_mask & res) != 0))) begin
                e.b_mask = e.b_mask & ~res;
                o.push_back(e);
            end
        end
        return o;
    endfunction

    task automatic model_step();
        ent_q_t   inc;
        ent_q_t   pool;
        CDB_ENTRY e;
        int       take;
        bit       stl;
        stl = (mq.size() > BUF_DEPTH - NUM_FU);
        if (!stl) begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (fu_valid[k]) begin
                    e.tag    = fu_tag[k*PB +: PB];
                    e.b_mask = fu_b_mask[k*BW +: BW];
                    inc.push_back(e);
                end
            end
        end
        mq  = squash(mq, b_mm_resolve, b_mm_mispred);
        inc = squash(inc, b_mm_resolve, b_mm_mispred);
        pool = mq;
        if (BYP) foreach (inc[i]) pool.push_back(inc[i]);
        take    = (pool.size() < N) ? pool.size() : N;
        m_valid = '0;
        m_tags  = '0;
        for (int l = 0; l < take; l++) begin
            m_valid[l]          = 1'b1;
            m_tags[l*PB +: PB]  = pool[l].tag;
        end
        repeat (take) void'(pool.pop_front());
        if (!BYP) foreach (inc[i]) pool.push_back(inc[i]);
        mq = pool;
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mq.delete();
                m_valid = '0;
                m_tags  = '0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            check("cyc_valid", 32'(CDB_valid), 32'(m_valid));
            check("cyc_tags", 32'(CDB_tags), 32'(m_tags));
            check("cyc_count", 32'(buf_count), 32'(mq.size()));
            check("cyc_stall", 32'(fu_stall), (mq.size() > BUF_DEPTH - NUM_FU) ? 32'hF : 32'h0);
        end
    end

    logic [63:0] seen;
    int          max_cnt;
    bit          saw_stall;

    task automatic observe();
        for (int l = 0; l < N; l++) begin
            if (CDB_valid[l]) seen[CDB_tags[l*PB +: PB]] = 1'b1;
        end
        if (int'(buf_count) > max_cnt) max_cnt = int'(buf_count);
        if (fu_stall == 4'hF) saw_stall = 1'b1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [23:0] tg, input logic [15:0] mk,
                         input logic [3:0] res, input logic mis);
        @(negedge clock);
        observe();
        fu_valid     = v;
        fu_tag       = tg;
        fu_b_mask    = mk;
        b_mm_resolve = res;
        b_mm_mispred = mis;
    endtask

    task automatic idle();
        drive(4'h0, 24'h0, 16'h0, 4'h0, 1'b0);
    endtask

    initial begin
        seen      = '0;
        max_cnt   = 0;
        saw_stall = 1'b0;

        // Reset held, then released with no inputs.
        repeat (3) begin
            @(negedge clock);
            check("rst_valid", 32'(CDB_valid), 32'h0);
            check("rst_count", 32'(buf_count), 32'h0);
            check("rst_stall", 32'(fu_stall), 32'h0);
        end
        #2 reset = 1'b1;
        repeat (3) begin
            idle();
            check("idle_valid", 32'(CDB_valid), 32'h0);
            check("idle_count", 32'(buf_count), 32'h0);
        end

        // Single result, tag 7 on port 0.
        drive(4'b0001, 24'd7, 16'h0, 4'h0, 1'b0);
        repeat (LAT) idle();
        check("single_valid", 32'(CDB_valid), 32'h1);
        check("single_tag", 32'(CDB_tags), 32'd7);
        repeat (2) idle();
        check("single_drain", 32'(buf_count), 32'h0);

        // Burst of four in one cycle leaves in FU order, two per cycle.
        drive(4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 16'h0, 4'h0, 1'b0);
        repeat (LAT) idle();
        check("burst_v0", 32'(CDB_valid), 32'h3);
        check("burst_t0", 32'(CDB_tags), 32'({6'd11, 6'd10}));
        idle();
        check("burst_v1", 32'(CDB_valid), 32'h3);
        check("burst_t1", 32'(CDB_tags), 32'({6'd13, 6'd12}));
        idle();
        check("burst_v2", 32'(CDB_valid), 32'h0);

        // Mispredict squash of a stored entry behind older traffic.
        repeat (4) idle();
        seen = '0;
        drive(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 16'h0, 4'h0, 1'b0);
        drive(4'b0011, {12'd0, 6'd21, 6'd20}, {8'h0, 4'b0001, 4'b0010}, 4'h0, 1'b0);
        drive(4'b0000, 24'h0, 16'h0, 4'b0010, 1'b1);
        repeat (5) idle();
        check("squash_20_hidden", 32'(seen[20]), 32'h0);
        check("squash_21_sent", 32'(seen[21]), 32'h1);
        check("squash_fill_sent", 32'(seen[4:1]), 32'hF);
        check("squash_drain", 32'(buf_count), 32'h0);

        // Correct resolve clears the bit, so a later mispredict on it keeps the entry.
        seen = '0;
        drive(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 16'h0, 4'h0, 1'b0);
        drive(4'b0001, {18'd0, 6'd30}, {12'h0, 4'b0011}, 4'b0001, 1'b0);
        drive(4'b0000, 24'h0, 16'h0, 4'b0001, 1'b1);
        repeat (5) idle();
        check("resolve_30_sent", 32'(seen[30]), 32'h1);

        // Backpressure: four results every cycle.
        max_cnt   = 0;
        saw_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, {6'(40 + 4*i + 3), 6'(40 + 4*i + 2), 6'(40 + 4*i + 1), 6'(40 + 4*i)},
                  16'h0, 4'h0, 1'b0);
        end
        repeat (8) idle();
        check("bp_saw_stall", 32'(saw_stall), 32'h1);
        check("bp_max_le_8", 32'(max_cnt <= BUF_DEPTH), 32'h1);
        check("bp_drain", 32'(buf_count), 32'h0);

        // Randomized traffic with a reset asserted mid-stream.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] res;
            logic       mis;
            res = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            mis = (res != 0) && ($urandom_range(0, 1) == 1);
            drive(4'($urandom), 24'($urandom), 16'($urandom & $urandom), res, mis);
            if (i == 1500) begin
                @(negedge clock);
                #2 reset = 1'b0;
                #1;
                check("midrst_count", 32'(buf_count), 32'h0);
                check("midrst_valid", 32'(CDB_valid), 32'h0);
                @(negedge clock);
                #2 reset = 1'b1;
            end
        end
        repeat (8) idle();
        check("final_drain", 32'(buf_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
